led_step_ctrl: RTL

Upstream control stage for the board LED display. It debounces three raw push-buttons (up, down, pause) and turns them into single-cycle press pulses. It holds a 3-bit speed level and a pause flag, and generates a one-cycle `step` strobe at a speed-dependent period. The downstream LED pattern stage advances its pattern on every `step` and ignores its own free-running timer.

---
 rtl/led_step_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/led_step_ctrl.sv
// rtl/led_step_ctrl.sv - button debounce, speed/pause control and step strobe for the LED display
//
// Debounces three raw push-buttons into one-cycle press pulses, keeps a
// saturating 3-bit speed level and a pause flag, and emits a one-cycle step
// strobe every BASE_PERIOD * (8 - speed) cycles while not paused.
//
// Ports:
//   clk100mhz  in   1  system clock
//   rst        in   1  synchronous active-high reset
//   btn_up     in   1  raw asynchronous button, active-high
//   btn_down   in   1  raw asynchronous button, active-high
//   btn_pause  in   1  raw asynchronous button, active-high
//   btn_pulse  out  3  one-cycle press pulses {pause, down, up}
//   speed      out  3  speed level, 0 slowest .. 7 fastest
//   paused     out  1  stepping suspended
//   step       out  1  one-cycle advance strobe

module led_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BASE_PERIOD     = 2_500_000
) (
    input  logic       clk100mhz,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_pause,
    output logic [2:0] btn_pulse,
    output logic [2:0] speed,
    output logic       paused,
    output logic       step
);

    // The counter only ever reaches DEBOUNCE_CYCLES-1 before it clears.
    localparam int             DB_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      stable;
    logic [2:0]      stable_d;
    logic [DB_W-1:0] db_cnt [3];

    logic [2:0]  speed_next;
    logic        speed_change;
    logic [31:0] period;
    logic [31:0] period_next;
    logic [31:0] cnt;

    assign raw = {btn_pause, btn_down, btn_up};

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching
    // samples; any matching sample restarts the count.
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Rising edge of the debounced level, registered.
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            stable_d  <= '0;
            btn_pulse <= '0;
        end else begin
            stable_d  <= stable;
            btn_pulse <= stable & ~stable_d;
        end
    end

    // Opposing up/down pulses cancel.
    always_comb begin
        speed_next = speed;
        if (btn_pulse[0] && !btn_pulse[1] && speed != 3'd7) begin
            speed_next = speed + 3'd1;
        end else if (btn_pulse[1] && !btn_pulse[0] && speed != 3'd0) begin
            speed_next = speed - 3'd1;
        end
    end

    assign speed_change = (speed_next != speed);

    // Computed from speed_next so the registered period always matches the
    // registered speed, with no stale-period cycle after a change.
    assign period_next = 32'(BASE_PERIOD) * {28'd0, 4'd8 - {1'b0, speed_next}};

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            speed  <= 3'd3;
            paused <= 1'b0;
            period <= 32'(BASE_PERIOD) * 32'd5;
        end else begin
            speed  <= speed_next;
            paused <= paused ^ btn_pulse[2];
            period <= period_next;
        end
    end

    // Step timer; a speed change restarts the period and suppresses any
    // strobe that would have fired in the same cycle.
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (speed_change) begin
            cnt  <= '0;
            step <= 1'b0;
        end else if (paused) begin
            step <= 1'b0;
        end else if (cnt == period - 32'd1) begin
            cnt  <= '0;
            step <= 1'b1;
        end else begin
            cnt  <= cnt + 32'd1;
            step <= 1'b0;
        end
    end

endmodule
